booth_mult_seq: RTL and testbench

- Iterative radix-2 Booth signed multiplier for the CPU datapath; produces the 64-bit HI/LO product for the MUL instruction.
- Sits beside the ALU adder. Takes operands from the register-file read ports (Y/bus path) and delivers product_hi/product_lo to the HI and LO registers.
- Performs one add/subtract-and-shift step per clock, so a single narrow add stage replaces a combinational array multiplier.

---
 rtl/mult_pkg.sv | 40 ++++
 rtl/booth_step.sv | 45 ++++
 rtl/booth_mult_seq.sv | 122 ++++++++++++
 tb/tb_booth_mult_seq.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the sequential radix-2 Booth multiplier.
//   - mult_state_t : controller states (IDLE / RUN / DONE)
//   - booth_op_t   : Booth recoding of {Q[0], q_m1} (NOP / ADD / SUB)
//   - booth_decode : maps the two recoding bits onto booth_op_t
// ---------------------------------------------------------------------------
package mult_pkg;

  localparam int MULT_WIDTH_DEF = 32;
  localparam int MULT_CNT_W_DEF = 6;

  localparam logic [1:0] ST_IDLE_ENC = 2'b00;
  localparam logic [1:0] ST_RUN_ENC  = 2'b01;
  localparam logic [1:0] ST_DONE_ENC = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = ST_IDLE_ENC,
    ST_RUN  = ST_RUN_ENC,
    ST_DONE = ST_DONE_ENC
  } mult_state_t;

  typedef enum logic [1:0] {
    BOOTH_NOP = 2'b00,
    BOOTH_ADD = 2'b01,
    BOOTH_SUB = 2'b10
  } booth_op_t;

  // 01 -> end of a run of ones: add M; 10 -> start of a run of ones: subtract M.
  function automatic booth_op_t booth_decode(input logic q0, input logic q_m1);
    booth_op_t op;
    case ({q0, q_m1})
      2'b01:   op = BOOTH_ADD;
      2'b10:   op = BOOTH_SUB;
      default: op = BOOTH_NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_step.sv
// ---------------------------------------------------------------------------
// booth_step
// One combinational radix-2 Booth iteration: add/subtract M into the
// accumulator according to {qreg[0], q_m1}, then arithmetic-shift the
// concatenation {sum, qreg, q_m1} right by one bit.
// Ports:
//   acc        in  WIDTH+1  current accumulator (signed)
//   mreg       in  WIDTH+1  sign-extended multiplicand
//   qreg       in  WIDTH    current multiplier/low-product register
//   q_m1       in  1        previous multiplier LSB
//   acc_next   out WIDTH+1  accumulator after add and shift
//   qreg_next  out WIDTH    Q register after shift
//   q_m1_next  out 1        bit shifted out of the Q register
// ---------------------------------------------------------------------------
module booth_step
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH_DEF
) (
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH:0]   mreg,
  input  logic [WIDTH-1:0] qreg,
  input  logic             q_m1,
  output logic [WIDTH:0]   acc_next,
  output logic [WIDTH-1:0] qreg_next,
  output logic             q_m1_next
);

  booth_op_t      op;
  logic [WIDTH:0] sum;

  always_comb begin
    op  = booth_decode(qreg[0], q_m1);
    sum = acc;
    case (op)
      BOOTH_ADD: sum = acc + mreg;
      BOOTH_SUB: sum = acc + (~mreg + 1'b1);
      default:   sum = acc;
    endcase
    // The extra accumulator bit keeps -M representable for M = -2^(WIDTH-1),
    // so replicating sum's MSB is a true arithmetic shift.
    {acc_next, qreg_next, q_m1_next} = {sum[WIDTH], sum, qreg};
  end

endmodule

// File: rtl/booth_mult_seq.sv
// ---------------------------------------------------------------------------
// booth_mult_seq
// Iterative radix-2 Booth signed multiplier, one Booth step per clock.
// Optional feature macro: BOOTH_MULT_ZERO_SKIP_EN -- when defined, a start
// with a zero operand jumps straight to DONE with a zero product.
// Ports:
//   clock         in  1      system clock (rising edge)
//   clear         in  1      synchronous active-high reset
//   start         in  1      request, sampled only in IDLE
//   multiplicand  in  WIDTH  signed operand M
//   multiplier    in  WIDTH  signed operand Q
//   busy          out 1      high while iterating (RUN)
//   done          out 1      one-cycle pulse, product valid
//   product_hi    out WIDTH  upper half of the signed product
//   product_lo    out WIDTH  lower half of the signed product
// ---------------------------------------------------------------------------
module booth_mult_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH_DEF,
  parameter int CNT_W = MULT_CNT_W_DEF
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  mult_state_t      state_reg, state_next;
  logic [WIDTH:0]   acc_reg, mreg_reg;
  logic [WIDTH-1:0] qreg_reg;
  logic             q_m1_reg;
  logic [CNT_W-1:0] count_reg;
  logic [WIDTH-1:0] prod_hi_reg, prod_lo_reg;
  logic             done_reg;

  logic [WIDTH:0]   acc_step;
  logic [WIDTH-1:0] qreg_step;
  logic             q_m1_step;
  logic             zero_op;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .acc       (acc_reg),
    .mreg      (mreg_reg),
    .qreg      (qreg_reg),
    .q_m1      (q_m1_reg),
    .acc_next  (acc_step),
    .qreg_next (qreg_step),
    .q_m1_next (q_m1_step)
  );

`ifdef BOOTH_MULT_ZERO_SKIP_EN
  assign zero_op = (multiplicand == '0) || (multiplier == '0);
`else
  assign zero_op = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start) state_next = zero_op ? ST_DONE : ST_RUN;
      ST_RUN:  if (count_reg == LAST_STEP) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_reg   <= ST_IDLE;
      acc_reg     <= '0;
      mreg_reg    <= '0;
      qreg_reg    <= '0;
      q_m1_reg    <= 1'b0;
      count_reg   <= '0;
      prod_hi_reg <= '0;
      prod_lo_reg <= '0;
      done_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            acc_reg   <= '0;
            mreg_reg  <= {multiplicand[WIDTH-1], multiplicand};
            // A skipped zero operation reaches DONE with acc/Q cleared,
            // so the normal DONE path publishes a zero product.
            qreg_reg  <= zero_op ? '0 : multiplier;
            q_m1_reg  <= 1'b0;
            count_reg <= '0;
          end
        end
        ST_RUN: begin
          acc_reg   <= acc_step;
          qreg_reg  <= qreg_step;
          q_m1_reg  <= q_m1_step;
          count_reg <= count_reg + 1'b1;
        end
        ST_DONE: begin
          prod_hi_reg <= acc_reg[WIDTH-1:0];
          prod_lo_reg <= qreg_reg;
          done_reg    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy       = (state_reg == ST_RUN);
  assign done       = done_reg;
  assign product_hi = prod_hi_reg;
  assign product_lo = prod_lo_reg;

endmodule

// File: tb/tb_booth_mult_seq.sv
// ---------------------------------------------------------------------------
// tb_booth_mult_seq
// Self-checking bench for booth_mult_seq: directed vector table, random
// operands against a plain signed-multiply reference, and hand-written
// sequences for clear mid-operation, start while busy and held start.
// ---------------------------------------------------------------------------
module tb_booth_mult_seq;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         clear;
  logic         start;
  logic [W-1:0] multiplicand;
  logic [W-1:0] multiplier;
  logic         busy;
  logic         done;
  logic [W-1:0] product_hi;
  logic [W-1:0] product_lo;

  int checks   = 0;
  int failures = 0;

  booth_mult_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clock        (clock),
    .clear        (clear),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product_hi   (product_hi),
    .product_lo   (product_lo)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0] m;
    logic [W-1:0] q;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] m, input logic [W-1:0] q);
    longint a, b;
    a = longint'($signed(m));
    b = longint'($signed(q));
    return 64'(a * b);
  endfunction

  function automatic int exp_latency(input logic [W-1:0] m, input logic [W-1:0] q);
`ifdef BOOTH_MULT_ZERO_SKIP_EN
    if (m == '0 || q == '0) return 1;
`endif
    return W + 1;
  endfunction

  function automatic int exp_busy(input logic [W-1:0] m, input logic [W-1:0] q);
`ifdef BOOTH_MULT_ZERO_SKIP_EN
    if (m == '0 || q == '0) return 0;
`endif
    return W;
  endfunction

  // Pulses start for one edge, then watches at negedges. k counts edges
  // after the start edge; lat is the k at which done is first seen.
  task automatic run_op(input logic [W-1:0] m, input logic [W-1:0] q,
                        output logic [W-1:0] hi, output logic [W-1:0] lo,
                        output int lat, output int busy_cnt, output int both_hi);
    @(negedge clock);
    multiplicand = m;
    multiplier   = q;
    start        = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start        = 1'b0;
    multiplicand = $urandom;   // operands must have been captured already
    multiplier   = $urandom;
    lat = -1; busy_cnt = 0; both_hi = 0; hi = '0; lo = '0;
    for (int k = 0; k < 100; k++) begin
      if (k > 0) begin
        @(posedge clock);
        @(negedge clock);
      end
      if (busy) busy_cnt++;
      if (busy && done) both_hi++;
      if (done) begin
        lat = k; hi = product_hi; lo = product_lo;
        break;
      end
    end
    if (lat < 0) $display("FAIL done_timeout m=0x%0h q=0x%0h actual=none required=done", m, q);
  endtask

  task automatic check_op(input string tag, input logic [W-1:0] m, input logic [W-1:0] q,
                          input logic [2*W-1:0] expv);
    logic [W-1:0] hi, lo;
    int lat, bc, both;
    run_op(m, q, hi, lo, lat, bc, both);
    chk({tag, "_latency"}, lat, exp_latency(m, q));
    chk({tag, "_busy_cycles"}, bc, exp_busy(m, q));
    chk({tag, "_busy_and_done"}, both, 0);
    chk({tag, "_hi"}, hi, expv[2*W-1:W]);
    chk({tag, "_lo"}, lo, expv[W-1:0]);
    @(posedge clock);
    @(negedge clock);
    chk({tag, "_done_one_cycle"}, done, 0);
    chk({tag, "_hold_lo"}, product_lo, expv[W-1:0]);
    $display("op %-8s M=0x%08h Q=0x%08h -> hi=0x%08h lo=0x%08h lat=%0d", tag, m, q, hi, lo, lat);
  endtask

  vec_t vecs[7];

  initial begin
    logic [W-1:0] rm, rq;
    int dcount, dk1, dk2;
    logic [W-1:0] lo_seen, lo1, lo2;

    vecs[0] = '{32'd3,        32'd5,        32'h00000000, 32'h0000000F};
    vecs[1] = '{32'hFFFFFFF9, 32'd6,        32'hFFFFFFFF, 32'hFFFFFFD6};
    vecs[2] = '{32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[4] = '{32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000};
    vecs[5] = '{32'h00000000, 32'h00001234, 32'h00000000, 32'h00000000};
    vecs[6] = '{32'h00001234, 32'h00000000, 32'h00000000, 32'h00000000};

    clear = 1'b1; start = 1'b1; multiplicand = 32'd7; multiplier = 32'd7;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_hi", product_hi, 0);
    chk("reset_lo", product_lo, 0);
    clear = 1'b0; start = 1'b0;
    $display("reset checked");

    // Directed table
    for (int i = 0; i < 7; i++)
      check_op($sformatf("vec%0d", i), vecs[i].m, vecs[i].q, {vecs[i].hi, vecs[i].lo});

    // Random operands against the reference multiply
    for (int i = 0; i < 20; i++) begin
      rm = $urandom;
      rq = $urandom;
      if (i % 5 == 1) rm = rm >> $urandom_range(31, 0);
      if (i % 7 == 3) rq = 32'h80000000 | (rq & 32'h1);
      check_op($sformatf("rnd%0d", i), rm, rq, ref_mul(rm, rq));
    end

    // Clear in the middle of an operation
    @(negedge clock);
    multiplicand = 32'd9; multiplier = 32'd9; start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (10) @(negedge clock);
    clear = 1'b1;
    @(posedge clock);
    @(negedge clock);
    clear = 1'b0;
    chk("clr_busy", busy, 0);
    chk("clr_done", done, 0);
    chk("clr_hi", product_hi, 0);
    chk("clr_lo", product_lo, 0);
    dcount = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (done || busy) dcount++;
    end
    chk("clr_no_activity", dcount, 0);
    $display("clear mid-operation checked");
    check_op("after_clr", 32'd2, 32'd4, ref_mul(32'd2, 32'd4));

    // Start while busy must be ignored
    @(negedge clock);
    multiplicand = 32'd2; multiplier = 32'd3; start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    dcount = 0; lo_seen = '0;
    for (int k = 1; k < 90; k++) begin
      @(negedge clock);
      if (k == 5) begin
        start = 1'b1; multiplicand = 32'd100; multiplier = 32'd100;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        dcount++;
        lo_seen = product_lo;
      end
    end
    chk("busy_start_done_count", dcount, 1);
    chk("busy_start_lo", lo_seen, 32'd6);
    $display("start while busy checked: dones=%0d lo=%0d", dcount, lo_seen);

    // Start held high: back-to-back operations, one DONE cycle between
    @(negedge clock);
    multiplicand = 32'd5; multiplier = 32'd7; start = 1'b1;
    @(posedge clock);
    dk1 = -1; dk2 = -1; lo1 = '0; lo2 = '0;
    for (int k = 0; k < 120; k++) begin
      if (k > 0) @(posedge clock);
      @(negedge clock);
      if (done && dk1 < 0) begin
        dk1 = k; lo1 = product_lo;
        multiplicand = 32'hFFFFFFFD; multiplier = 32'd11;
      end else if (done && dk2 < 0) begin
        dk2 = k; lo2 = product_lo;
        start = 1'b0;
        break;
      end
    end
    start = 1'b0;
    chk("b2b_first_latency", dk1, W + 1);
    chk("b2b_second_latency", dk2, 2 * (W + 1) + 1);
    chk("b2b_first_lo", lo1, 32'd35);
    chk("b2b_second_lo", lo2, 32'hFFFFFFDF);
    $display("back-to-back checked: done at %0d and %0d", dk1, dk2);

    repeat (3) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
